// File: rtl/nanorv32_rf_writeback.sv
// rtl/nanorv32_rf_writeback.sv - register file write-back merge of execute results and in-order load responses
// Owns the pending-load scoreboard, the load tag queue and the issue hazard stall.
module nanorv32_rf_writeback #(
  parameter int NUM_REGS = 32,
  parameter int LQ_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ex_valid,
  input  logic                      ex_is_load,
  input  logic [4:0]                ex_rd,
  input  logic [31:0]               ex_data,
  output logic                      ex_ready,
  input  logic                      lsu_rsp_valid,
  input  logic [31:0]               lsu_rsp_data,
  output logic                      lsu_rsp_ready,
  input  logic [4:0]                hz_rs1,
  input  logic [4:0]                hz_rs2,
  output logic                      hz_stall,
  input  logic                      allow_hidden_use_of_x0,
  output logic [4:0]                sel_rd,
  output logic [31:0]               rd,
  output logic                      write_rd,
  output logic [4:0]                sel_rd2,
  output logic [31:0]               rd2,
  output logic                      write_rd2,
  output logic [NUM_REGS-1:0]       pending,
  output logic [$clog2(LQ_DEPTH):0] lq_count
);

  localparam int AW = $clog2(LQ_DEPTH);
  localparam int CW = AW + 1;

  logic                write_rd_q, write_rd_d;
  logic [4:0]          sel_rd_q, sel_rd_d;
  logic [31:0]         rd_q, rd_d;
  logic                write_rd2_q, write_rd2_d;
  logic [4:0]          sel_rd2_q, sel_rd2_d;
  logic [31:0]         rd2_q, rd2_d;
  logic [NUM_REGS-1:0] pending_q, pending_d;
  logic [CW-1:0]       count_q, count_d;
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [4:0]          lq_rd_q [LQ_DEPTH];
  logic [4:0]          lq_rd_d [LQ_DEPTH];
  logic                lq_disc_q [LQ_DEPTH];
  logic                lq_disc_d [LQ_DEPTH];

  logic ex_acc, push, pop, lq_full;
  logic ex_act, rs1_act, rs2_act, hz1, hz2;

  // x0 behaves as a real register only while micro-ROM sequences ask for it.
  function automatic logic reg_active(input logic [4:0] r, input logic allow);
    return (r != 5'd0) || allow;
  endfunction

  assign lq_full       = (count_q == CW'(LQ_DEPTH));
  assign ex_ready      = !pending_q[ex_rd] && !(ex_is_load && lq_full);
  assign lsu_rsp_ready = (count_q != '0);
  assign ex_acc        = ex_valid && ex_ready;
  assign push          = ex_acc && ex_is_load;
  assign pop           = lsu_rsp_valid && lsu_rsp_ready;
  assign ex_act        = reg_active(ex_rd, allow_hidden_use_of_x0);
  assign rs1_act       = reg_active(hz_rs1, allow_hidden_use_of_x0);
  assign rs2_act       = reg_active(hz_rs2, allow_hidden_use_of_x0);

  assign hz1 = rs1_act && (pending_q[hz_rs1] || (write_rd_q && sel_rd_q == hz_rs1) ||
                           (write_rd2_q && sel_rd2_q == hz_rs1));
  assign hz2 = rs2_act && (pending_q[hz_rs2] || (write_rd_q && sel_rd_q == hz_rs2) ||
                           (write_rd2_q && sel_rd2_q == hz_rs2));
  assign hz_stall = hz1 || hz2;

  always_comb begin
    write_rd_d  = 1'b0;
    sel_rd_d    = sel_rd_q;
    rd_d        = rd_q;
    write_rd2_d = 1'b0;
    sel_rd2_d   = sel_rd2_q;
    rd2_d       = rd2_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    lq_rd_d     = lq_rd_q;
    lq_disc_d   = lq_disc_q;
    pending_d   = pending_q;

    if (ex_acc && !ex_is_load) begin
      write_rd_d = ex_act;
      sel_rd_d   = ex_rd;
      rd_d       = ex_data;
    end

    if (pop) begin
      write_rd2_d = !lq_disc_q[rd_ptr_q];
      sel_rd2_d   = lq_rd_q[rd_ptr_q];
      rd2_d       = lsu_rsp_data;
      rd_ptr_d    = rd_ptr_q + AW'(1);
    end

    // Discarded x0 loads still occupy a slot so their response gets consumed.
    if (push) begin
      lq_rd_d[wr_ptr_q]   = ex_rd;
      lq_disc_d[wr_ptr_q] = !ex_act;
      wr_ptr_d            = wr_ptr_q + AW'(1);
    end

    count_d = count_q + CW'(push) - CW'(pop);

    // Bit stays set through the write_rd2 cycle so readers stall until the RF holds the data.
    for (int i = 0; i < NUM_REGS; i++) begin
      if (write_rd2_q && sel_rd2_q == 5'(i)) pending_d[i] = 1'b0;
      if (push && ex_act && ex_rd == 5'(i)) pending_d[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_rd_q  <= 1'b0;
      sel_rd_q    <= '0;
      rd_q        <= '0;
      write_rd2_q <= 1'b0;
      sel_rd2_q   <= '0;
      rd2_q       <= '0;
      pending_q   <= '0;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      for (int i = 0; i < LQ_DEPTH; i++) begin
        lq_rd_q[i]   <= '0;
        lq_disc_q[i] <= 1'b0;
      end
    end else begin
      write_rd_q  <= write_rd_d;
      sel_rd_q    <= sel_rd_d;
      rd_q        <= rd_d;
      write_rd2_q <= write_rd2_d;
      sel_rd2_q   <= sel_rd2_d;
      rd2_q       <= rd2_d;
      pending_q   <= pending_d;
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      lq_rd_q     <= lq_rd_d;
      lq_disc_q   <= lq_disc_d;
    end
  end

  assign write_rd  = write_rd_q;
  assign sel_rd    = sel_rd_q;
  assign rd        = rd_q;
  assign write_rd2 = write_rd2_q;
  assign sel_rd2   = sel_rd2_q;
  assign rd2       = rd2_q;
  assign pending   = pending_q;
  assign lq_count  = count_q;

endmodule

// File: tb/tb_nanorv32_rf_writeback.sv
// tb/tb_nanorv32_rf_writeback.sv - self-checking bench for nanorv32_rf_writeback
// Reference model keeps the load tags as a queue and derives the scoreboard from its contents.
module tb_nanorv32_rf_writeback;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid = 1'b0, ex_is_load = 1'b0;
  logic [4:0]  ex_rd = '0;
  logic [31:0] ex_data = '0;
  logic        ex_ready;
  logic        lsu_rsp_valid = 1'b0;
  logic [31:0] lsu_rsp_data = '0;
  logic        lsu_rsp_ready;
  logic [4:0]  hz_rs1 = '0, hz_rs2 = '0;
  logic        hz_stall;
  logic        allow = 1'b0;
  logic [4:0]  sel_rd, sel_rd2;
  logic [31:0] rd, rd2;
  logic        write_rd, write_rd2;
  logic [31:0] pending;
  logic [2:0]  lq_count;

  nanorv32_rf_writeback #(.NUM_REGS(32), .LQ_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_rd(ex_rd), .ex_data(ex_data),
    .ex_ready(ex_ready),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_data(lsu_rsp_data), .lsu_rsp_ready(lsu_rsp_ready),
    .hz_rs1(hz_rs1), .hz_rs2(hz_rs2), .hz_stall(hz_stall),
    .allow_hidden_use_of_x0(allow),
    .sel_rd(sel_rd), .rd(rd), .write_rd(write_rd),
    .sel_rd2(sel_rd2), .rd2(rd2), .write_rd2(write_rd2),
    .pending(pending), .lq_count(lq_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] r;
    logic       disc;
  } ent_t;

  ent_t        q[$];
  logic        m_w1, m_w2;
  logic [4:0]  m_sel1, m_sel2;
  logic [31:0] m_d1, m_d2;
  int          total = 0, bad = 0;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", n, act, exp, $time);
    end
  endtask

  function automatic logic act_reg(input logic [4:0] r);
    return (r != 5'd0) || allow;
  endfunction

  function automatic logic [31:0] m_pend();
    logic [31:0] p = '0;
    foreach (q[k]) if (!q[k].disc) p[q[k].r] = 1'b1;
    if (m_w2) p[m_sel2] = 1'b1;
    return p;
  endfunction

  function automatic logic m_ready();
    logic [31:0] p = m_pend();
    return !p[ex_rd] && !(ex_is_load && q.size() == 4);
  endfunction

  function automatic logic m_hz(input logic [4:0] rs);
    logic [31:0] p = m_pend();
    return act_reg(rs) && (p[rs] || (m_w1 && m_sel1 == rs) || (m_w2 && m_sel2 == rs));
  endfunction

  task automatic m_reset();
    q.delete();
    m_w1 = 0; m_w2 = 0; m_sel1 = 0; m_sel2 = 0; m_d1 = 0; m_d2 = 0;
  endtask

  task automatic compare();
    chk("write_rd", 32'(write_rd), 32'(m_w1));
    chk("sel_rd", 32'(sel_rd), 32'(m_sel1));
    chk("rd", rd, m_d1);
    chk("write_rd2", 32'(write_rd2), 32'(m_w2));
    chk("sel_rd2", 32'(sel_rd2), 32'(m_sel2));
    chk("rd2", rd2, m_d2);
    chk("pending", pending, m_pend());
    chk("lq_count", 32'(lq_count), 32'(q.size()));
    chk("ex_ready", 32'(ex_ready), 32'(m_ready()));
    chk("lsu_rsp_ready", 32'(lsu_rsp_ready), 32'(q.size() != 0));
    chk("hz_stall", 32'(hz_stall), 32'(m_hz(hz_rs1) || m_hz(hz_rs2)));
  endtask

  task automatic drive(input logic v, input logic ld, input logic [4:0] r, input logic [31:0] d,
                       input logic rv, input logic [31:0] rdat, input logic [4:0] s1, input logic [4:0] s2);
    ex_valid = v; ex_is_load = ld; ex_rd = r; ex_data = d;
    lsu_rsp_valid = rv; lsu_rsp_data = rdat; hz_rs1 = s1; hz_rs2 = s2;
    #1;
    compare();
  endtask

  task automatic idle(input logic [4:0] s1, input logic [4:0] s2);
    drive(0, 0, 5'd0, 32'd0, 0, 32'd0, s1, s2);
  endtask

  // Advance the model across the coming edge, then move to just after it.
  task automatic tick();
    logic acc, pop;
    ent_t h;
    acc = ex_valid && m_ready();
    pop = lsu_rsp_valid && q.size() != 0;
    m_w1 = 0;
    m_w2 = 0;
    if (acc && !ex_is_load) begin
      m_w1 = act_reg(ex_rd); m_sel1 = ex_rd; m_d1 = ex_data;
    end
    if (pop) begin
      h = q.pop_front();
      m_w2 = !h.disc; m_sel2 = h.r; m_d2 = lsu_rsp_data;
    end
    if (acc && ex_is_load) q.push_back('{r: ex_rd, disc: !act_reg(ex_rd)});
    @(posedge clk);
    #1;
  endtask

  initial begin
    m_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    idle(5'd0, 5'd0);
    chk("reset pending", pending, 32'd0);
    chk("reset ex_ready", 32'(ex_ready), 32'd1);
    chk("reset rsp_ready", 32'(lsu_rsp_ready), 32'd0);
    chk("reset write_rd", 32'(write_rd), 32'd0);

    drive(1, 0, 5'd5, 32'h12345678, 0, 32'd0, 5'd0, 5'd0); tick();
    idle(5'd5, 5'd0);
    chk("alu write_rd", 32'(write_rd), 32'd1);
    chk("alu sel_rd", 32'(sel_rd), 32'd5);
    chk("alu rd", rd, 32'h12345678);
    chk("alu hz", 32'(hz_stall), 32'd1);
    tick();
    idle(5'd5, 5'd0);
    chk("alu hz gone", 32'(hz_stall), 32'd0);
    tick();

    drive(1, 1, 5'd7, 32'd0, 0, 32'd0, 5'd0, 5'd0); tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 5'd7, 32'd0, i == 2, 32'hDEADBEEF, 5'd0, 5'd7);
      chk("ld7 pending", pending, 32'h80);
      chk("ld7 hz", 32'(hz_stall), 32'd1);
      chk("ld7 ex_ready", 32'(ex_ready), 32'd0);
      tick();
    end
    idle(5'd0, 5'd7);
    chk("ld7 write_rd2", 32'(write_rd2), 32'd1);
    chk("ld7 sel_rd2", 32'(sel_rd2), 32'd7);
    chk("ld7 rd2", rd2, 32'hDEADBEEF);
    chk("ld7 hz wb", 32'(hz_stall), 32'd1);
    tick();
    idle(5'd0, 5'd7);
    chk("ld7 cleared", pending, 32'd0);
    tick();

    for (int i = 1; i <= 4; i++) begin
      drive(1, 1, 5'(i), 32'd0, 0, 32'd0, 5'd0, 5'd0); tick();
    end
    drive(1, 1, 5'd5, 32'd0, 0, 32'd0, 5'd0, 5'd0);
    chk("full count", 32'(lq_count), 32'd4);
    chk("full ex_ready", 32'(ex_ready), 32'd0);
    drive(1, 0, 5'd9, 32'h99, 0, 32'd0, 5'd0, 5'd0);
    chk("full alu ready", 32'(ex_ready), 32'd1);
    tick();
    drive(0, 0, 5'd0, 32'd0, 1, 32'h1001, 5'd0, 5'd0); tick();
    chk("drain x1", 32'(sel_rd2), 32'd1);
    drive(1, 1, 5'd5, 32'd0, 1, 32'h1002, 5'd0, 5'd0); tick();
    chk("push+pop count", 32'(lq_count), 32'd3);
    chk("drain x2", 32'(sel_rd2), 32'd2);
    for (int i = 3; i <= 5; i++) begin
      drive(0, 0, 5'd0, 32'd0, 1, 32'h1000 + i, 5'd0, 5'd0); tick();
      chk("drain order", 32'(sel_rd2), 32'(i));
    end
    idle(5'd0, 5'd0); tick();

    allow = 1'b0;
    drive(1, 1, 5'd0, 32'd0, 0, 32'd0, 5'd0, 5'd0); tick();
    drive(0, 0, 5'd0, 32'd0, 1, 32'h55, 5'd0, 5'd0); tick();
    idle(5'd0, 5'd0);
    chk("x0 off write_rd2", 32'(write_rd2), 32'd0);
    chk("x0 off pending", pending, 32'd0);
    chk("x0 off count", 32'(lq_count), 32'd0);
    allow = 1'b1;
    drive(1, 1, 5'd0, 32'd0, 0, 32'd0, 5'd0, 5'd0); tick();
    drive(0, 0, 5'd0, 32'd0, 1, 32'h66, 5'd0, 5'd0);
    chk("x0 on pending", pending, 32'd1);
    tick();
    idle(5'd0, 5'd0);
    chk("x0 on write_rd2", 32'(write_rd2), 32'd1);
    chk("x0 on sel_rd2", 32'(sel_rd2), 32'd0);
    tick();
    idle(5'd0, 5'd0);
    chk("x0 on cleared", pending, 32'd0);
    allow = 1'b0;

    drive(1, 1, 5'd8, 32'd0, 0, 32'd0, 5'd0, 5'd0); tick();
    drive(1, 0, 5'd3, 32'hA3A3, 1, 32'hB8B8, 5'd0, 5'd0); tick();
    idle(5'd0, 5'd0);
    chk("dual w1", 32'(write_rd), 32'd1);
    chk("dual w2", 32'(write_rd2), 32'd1);
    chk("dual data", rd ^ rd2, 32'hA3A3 ^ 32'hB8B8);
    chk("dual sels", {sel_rd, sel_rd2}, {22'd0, 5'd3, 5'd8});
    tick();

    for (int c = 0; c < 3000; c++) begin
      if (c % 250 == 0) allow = 1'($urandom_range(0, 1));
      drive(1'($urandom_range(0, 99) < 60), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
            $urandom, 1'($urandom_range(0, 99) < 40), $urandom,
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      tick();
    end

    allow = 1'b0;
    idle(5'd0, 5'd0);
    while (q.size() != 0) begin
      drive(0, 0, 5'd0, 32'd0, 1, $urandom, 5'd0, 5'd0); tick();
    end
    drive(1, 1, 5'd12, 32'd0, 0, 32'd0, 5'd0, 5'd0); tick();
    drive(1, 1, 5'd13, 32'd0, 0, 32'd0, 5'd0, 5'd0); tick();
    idle(5'd0, 5'd0);
    chk("pre-reset count", 32'(lq_count), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst count", 32'(lq_count), 32'd0);
    chk("async rst pending", pending, 32'd0);
    chk("async rst rsp_ready", 32'(lsu_rsp_ready), 32'd0);
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    idle(5'd12, 5'd13);
    chk("post rst hz", 32'(hz_stall), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
